icb_resp_stub: RTL and testbench

- Parametrised ICB slave that replaces the hard-wired loopback tie-offs on the sysper, sysfio and sysmem ports.
- Accepts commands and buffers up to DEPTH outstanding responses.
- Holds every response for a programmable minimum latency and returns them strictly in order.
- Backs reads and writes with a small scratch register file; out-of-range addresses return a bus error.

---
 rtl/icb_resp_stub.sv | 135 +++++++++++++
 tb/tb_icb_resp_stub.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_resp_stub.sv
// icb_resp_stub: ICB slave backed by a scratch register file, returning
// responses strictly in order after a programmable minimum latency.
module icb_resp_stub #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int LAT = 1,
  parameter int NWORDS = 8,
  parameter logic [DW-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic icb_cmd_valid,
  output logic icb_cmd_ready,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic icb_cmd_read,
  input  logic [DW-1:0] icb_cmd_wdata,
  input  logic [DW/8-1:0] icb_cmd_wmask,
  output logic icb_rsp_valid,
  input  logic icb_rsp_ready,
  output logic icb_rsp_err,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int NB = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = $clog2(NWORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int LIM = OFF + IW;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  logic [DW-1:0] mem_q [NWORDS];
  logic [DW-1:0] mem_d [NWORDS];
  logic [DW-1:0] rdata_q [DEPTH];
  logic [DW-1:0] rdata_d [DEPTH];
  logic err_q [DEPTH];
  logic err_d [DEPTH];
  logic [CW-1:0] cnt_q [DEPTH];
  logic [CW-1:0] cnt_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0] out_q, out_d;

  logic full;
  logic empty;
  logic rsp_valid;
  logic pop;
  logic push;
  logic in_range;
  logic [IW-1:0] widx;

  assign empty = (out_q == '0);
  assign full = (out_q == (PW+1)'(DEPTH));
  assign rsp_valid = !empty && (cnt_q[rptr_q] == '0);
  assign pop = rsp_valid && icb_rsp_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign icb_cmd_ready = rst_n && (!full || pop);
  assign push = icb_cmd_valid && icb_cmd_ready;

  assign widx = icb_cmd_addr[OFF +: IW];
  assign in_range = ((icb_cmd_addr >> LIM) == '0);

  assign icb_rsp_valid = rsp_valid;
  assign icb_rsp_err = rsp_valid & err_q[rptr_q];
  assign icb_rsp_rdata = rsp_valid ? rdata_q[rptr_q] : '0;
  assign outstanding = out_q;

  always_comb begin
    mem_d = mem_q;
    rdata_d = rdata_q;
    err_d = err_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    out_d = out_q;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : cnt_q[i];
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push) begin
      wptr_d = wptr_q + PW'(1);
      cnt_d[wptr_q] = CNT_INIT;
      err_d[wptr_q] = !in_range;
      if (!in_range) begin
        rdata_d[wptr_q] = ERR_RDATA;
      end else if (icb_cmd_read) begin
        rdata_d[wptr_q] = mem_q[widx];
      end else begin
        rdata_d[wptr_q] = '0;
        for (int b = 0; b < NB; b++) begin
          if (icb_cmd_wmask[b]) begin
            mem_d[widx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
          end
        end
      end
    end
    case ({push, pop})
      2'b10: out_d = out_q + (PW+1)'(1);
      2'b01: out_d = out_q - (PW+1)'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      out_q <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        mem_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        rdata_q[i] <= '0;
        err_q[i] <= 1'b0;
        cnt_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      out_q <= out_d;
      for (int i = 0; i < NWORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
        rdata_q[i] <= rdata_d[i];
        err_q[i] <= err_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_icb_resp_stub.sv
// Bench for icb_resp_stub: a LAT=1 and a LAT=3 instance share one command
// stream; a queue-based model checks both every cycle.
module tb_icb_resp_stub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_read = 1'b0;
  logic rsp_ready = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wmask = '0;

  logic [1:0] cmd_ready_w;
  logic [1:0] rsp_valid_w;
  logic [1:0] rsp_err_w;
  logic [1:0][31:0] rsp_rdata_w;
  logic [1:0][2:0] outst_w;

  int errors = 0;
  int checks = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    icb_resp_stub #(
      .AW(32), .DW(32), .DEPTH(4), .LAT(k == 0 ? 1 : 3),
      .NWORDS(8), .ERR_RDATA(32'hDEAD_BEEF)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .icb_cmd_valid(cmd_valid),
      .icb_cmd_ready(cmd_ready_w[k]),
      .icb_cmd_addr(cmd_addr),
      .icb_cmd_read(cmd_read),
      .icb_cmd_wdata(cmd_wdata),
      .icb_cmd_wmask(cmd_wmask),
      .icb_rsp_valid(rsp_valid_w[k]),
      .icb_rsp_ready(rsp_ready),
      .icb_rsp_err(rsp_err_w[k]),
      .icb_rsp_rdata(rsp_rdata_w[k]),
      .outstanding(outst_w[k])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per instance, a queue of pending responses, each
  // tagged with the first cycle it may be presented.
  typedef struct {
    logic err;
    logic [31:0] rdata;
    int due;
  } ent_t;

  ent_t mq[2][$];
  logic [31:0] mmem[2][8];
  bit rst_seen[2];
  int cyc = 0;

  task automatic model_cycle(input int k);
    bit ev, er, pp, acc;
    ent_t e;
    int idx, lat;
    logic [31:0] w;
    lat = (k == 0) ? 1 : 3;
    if (!rst_n) begin
      chk($sformatf("u%0d.rst_cmd_ready", k), 32'(cmd_ready_w[k]), 0);
      if (rst_seen[k]) begin
        chk($sformatf("u%0d.rst_valid", k), 32'(rsp_valid_w[k]), 0);
        chk($sformatf("u%0d.rst_outstanding", k), 32'(outst_w[k]), 0);
        chk($sformatf("u%0d.rst_err", k), 32'(rsp_err_w[k]), 0);
        chk($sformatf("u%0d.rst_rdata", k), rsp_rdata_w[k], 0);
      end
      mq[k].delete();
      for (int i = 0; i < 8; i++) mmem[k][i] = '0;
      rst_seen[k] = 1'b1;
      return;
    end
    rst_seen[k] = 1'b0;
    ev = (mq[k].size() > 0) && (cyc >= mq[k][0].due);
    er = (mq[k].size() < 4) || (ev && rsp_ready);
    chk($sformatf("u%0d.valid", k), 32'(rsp_valid_w[k]), 32'(ev));
    chk($sformatf("u%0d.cmd_ready", k), 32'(cmd_ready_w[k]), 32'(er));
    chk($sformatf("u%0d.outstanding", k), 32'(outst_w[k]),
        32'(mq[k].size()));
    if (ev) begin
      chk($sformatf("u%0d.err", k), 32'(rsp_err_w[k]),
          32'(mq[k][0].err));
      chk($sformatf("u%0d.rdata", k), rsp_rdata_w[k], mq[k][0].rdata);
    end else begin
      chk($sformatf("u%0d.idle_err", k), 32'(rsp_err_w[k]), 0);
      chk($sformatf("u%0d.idle_rdata", k), rsp_rdata_w[k], 0);
    end
    pp = ev && rsp_ready;
    acc = cmd_valid && er;
    if (pp) void'(mq[k].pop_front());
    if (acc) begin
      e.due = cyc + lat;
      if (cmd_addr < 32) begin
        idx = int'(cmd_addr / 4);
        e.err = 1'b0;
        if (cmd_read) begin
          e.rdata = mmem[k][idx];
        end else begin
          e.rdata = '0;
          w = mmem[k][idx];
          for (int b = 0; b < 4; b++)
            if (cmd_wmask[b]) w[8*b +: 8] = cmd_wdata[8*b +: 8];
          mmem[k][idx] = w;
        end
      end else begin
        e.err = 1'b1;
        e.rdata = 32'hDEAD_BEEF;
      end
      mq[k].push_back(e);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_cycle(k);
      cyc++;
    end
  end

  task automatic drv(input logic v, input logic rd, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m);
    cmd_valid = v;
    cmd_read = rd;
    cmd_addr = a;
    cmd_wdata = wd;
    cmd_wmask = m;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      mid();
      nxt();
    end
  endtask

  logic [31:0] t4_exp[4];
  int n;
  int sel;

  initial begin : main
    t4_exp[0] = 32'h1234_5678;
    t4_exp[1] = 32'hAA22_CC44;
    t4_exp[2] = 32'hC0C0_C0C0;
    t4_exp[3] = 32'h1010_1010;

    // reset state
    repeat (2) nxt();
    mid();
    chk("reset_ready", 32'(cmd_ready_w[0]), 0);
    chk("reset_valid", 32'(rsp_valid_w[0]), 0);
    chk("reset_outstanding", 32'(outst_w[0]), 0);
    chk("reset_rdata", rsp_rdata_w[0], 0);
    nxt();
    rst_n = 1'b1;

    // write then read, LAT=1
    drv(1, 0, 32'h4, 32'h1234_5678, 4'hF);
    mid();
    chk("t1_wr_ready", 32'(cmd_ready_w[0]), 1);
    nxt();
    drv(1, 1, 32'h4, 0, 0);
    mid();
    chk("t1_wr_rsp_valid", 32'(rsp_valid_w[0]), 1);
    chk("t1_wr_rsp_rdata", rsp_rdata_w[0], 0);
    chk("t1_wr_rsp_err", 32'(rsp_err_w[0]), 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t1_rd_rsp_valid", 32'(rsp_valid_w[0]), 1);
    chk("t1_rd_rsp_rdata", rsp_rdata_w[0], 32'h1234_5678);
    chk("t1_rd_rsp_err", 32'(rsp_err_w[0]), 0);
    nxt();

    // byte mask
    drv(1, 0, 32'h8, 32'hAABB_CCDD, 4'hF);
    mid(); nxt();
    drv(1, 0, 32'h8, 32'h1122_3344, 4'b0101);
    mid(); nxt();
    drv(1, 1, 32'h8, 0, 0);
    mid(); nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t2_mask_rdata", rsp_rdata_w[0], 32'hAA22_CC44);
    nxt();

    // out of range
    drv(1, 1, 32'h20, 0, 0);
    mid(); nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t3_oor_rd_err", 32'(rsp_err_w[0]), 1);
    chk("t3_oor_rd_rdata", rsp_rdata_w[0], 32'hDEAD_BEEF);
    nxt();
    drv(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
    mid(); nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t3_oor_wr_err", 32'(rsp_err_w[0]), 1);
    chk("t3_oor_wr_rdata", rsp_rdata_w[0], 32'hDEAD_BEEF);
    nxt();
    drv(1, 1, 32'h4, 0, 0);
    mid(); nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t3_scratch_kept", rsp_rdata_w[0], 32'h1234_5678);
    nxt();
    idle_n(6);

    // backpressure / full
    drv(1, 0, 32'h0, 32'hA0A0_A0A0, 4'hF);
    mid(); nxt();
    drv(1, 0, 32'hC, 32'hC0C0_C0C0, 4'hF);
    mid(); nxt();
    drv(1, 0, 32'h10, 32'h1010_1010, 4'hF);
    mid(); nxt();
    idle_n(6);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 32'(i * 4), 0, 0);
      mid();
      chk($sformatf("t4_accept%0d", i), 32'(cmd_ready_w[0]), 1);
      nxt();
    end
    drv(1, 1, 32'h10, 0, 0);
    mid();
    chk("t4_full_ready", 32'(cmd_ready_w[0]), 0);
    chk("t4_full_outstanding", 32'(outst_w[0]), 4);
    nxt();
    rsp_ready = 1'b1;
    mid();
    chk("t4_popthru_ready", 32'(cmd_ready_w[0]), 1);
    chk("t4_popthru_rdata", rsp_rdata_w[0], 32'hA0A0_A0A0);
    nxt();
    rsp_ready = 1'b0;
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t4_still4", 32'(outst_w[0]), 4);
    chk("t4_hold_rdata", rsp_rdata_w[0], 32'h1234_5678);
    nxt();
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      mid();
      if (rsp_valid_w[0]) begin
        chk($sformatf("t4_order%0d", n), rsp_rdata_w[0], t4_exp[n]);
        n++;
      end
      nxt();
    end
    chk("t4_rsp_count", 32'(n), 4);
    idle_n(6);

    // latency, LAT=3 instance
    drv(1, 1, 32'h4, 0, 0);
    mid();
    chk("t5_c0_valid", 32'(rsp_valid_w[1]), 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t5_c1_valid", 32'(rsp_valid_w[1]), 0);
    nxt();
    mid();
    chk("t5_c2_valid", 32'(rsp_valid_w[1]), 0);
    nxt();
    mid();
    chk("t5_c3_valid", 32'(rsp_valid_w[1]), 1);
    chk("t5_c3_rdata", rsp_rdata_w[1], 32'h1234_5678);
    nxt();
    drv(1, 1, 32'h0, 0, 0);
    mid(); nxt();
    drv(1, 1, 32'h8, 0, 0);
    mid(); nxt();
    drv(1, 1, 32'hC, 0, 0);
    mid();
    chk("t5_gap_valid", 32'(rsp_valid_w[1]), 0);
    nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t5_b0", rsp_rdata_w[1], 32'hA0A0_A0A0);
    nxt();
    mid();
    chk("t5_b1", rsp_rdata_w[1], 32'hAA22_CC44);
    nxt();
    mid();
    chk("t5_b2", rsp_rdata_w[1], 32'hC0C0_C0C0);
    nxt();
    idle_n(4);

    // reset mid-flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 32'(i * 4), 0, 0);
      mid(); nxt();
    end
    drv(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    mid();
    chk("t6_rst_ready", 32'(cmd_ready_w[0]), 0);
    nxt();
    rst_n = 1'b1;
    mid();
    chk("t6_valid0", 32'(rsp_valid_w[0]), 0);
    chk("t6_outst0", 32'(outst_w[0]), 0);
    chk("t6_valid1", 32'(rsp_valid_w[1]), 0);
    chk("t6_outst1", 32'(outst_w[1]), 0);
    nxt();
    rsp_ready = 1'b1;
    drv(1, 1, 32'h0, 0, 0);
    mid(); nxt();
    drv(0, 0, 0, 0, 0);
    mid();
    chk("t6_read_valid", 32'(rsp_valid_w[0]), 1);
    chk("t6_read_zero", rsp_rdata_w[0], 0);
    nxt();

    // randomized traffic with varying backpressure and rare resets
    for (int seg = 0; seg < 3; seg++) begin
      for (int i = 0; i < 1000; i++) begin
        rst_n = ($urandom_range(0, 399) != 0);
        rsp_ready = ($urandom_range(0, 3) > seg);
        sel = int'($urandom_range(0, 9));
        drv($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
            (sel < 8) ? 32'($urandom_range(0, 31)) :
            (sel == 8) ? 32'(32 + $urandom_range(0, 31)) : $urandom,
            $urandom, 4'($urandom_range(0, 15)));
        mid(); nxt();
      end
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    idle_n(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
